// File: rtl/hash_result_collector_pkg.sv
// Shared collector definitions: FSM encodings, nonce geometry and the default macro count.
// The optional result interrupt is enabled by defining DECRED_RESULT_IRQ_EN.
`ifndef DECRED_DEFINES_DONE
`define DECRED_DEFINES_DONE
`ifndef NUMBER_OF_MACROS
`define NUMBER_OF_MACROS 4
`endif
`define COLLECT_IDLE    2'd0
`define COLLECT_READ    2'd1
`define COLLECT_HOLDOFF 2'd2
`define NONCE_BYTES     4
`define NONCE_BASE_ADDR 6'h34
`endif

package hash_result_collector_pkg;
    localparam logic [1:0] ST_IDLE    = `COLLECT_IDLE;
    localparam logic [1:0] ST_READ    = `COLLECT_READ;
    localparam logic [1:0] ST_HOLDOFF = `COLLECT_HOLDOFF;
    localparam int         NONCE_BYTES = `NONCE_BYTES;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/hash_result_collector_fifo.sv
// Single-clock result FIFO with registered head, count and full/empty flags.
// A pop and a push in the same cycle are both honoured, even when full.
module result_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    wdata,
    output logic [W-1:0]    rdata,
    output logic            empty,
    output logic            full,
    output logic [CNTW-1:0] count
);
    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic            r_empty;
    logic            r_full;
    logic [W-1:0]    r_head;
    logic            w_do_pop;
    logic            w_do_push;
    logic [CNTW-1:0] w_count_next;

    assign w_do_pop  = pop && !r_empty;
    assign w_do_push = push && (!r_full || w_do_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop)
            w_count_next = r_count + CNTW'(1);
        else if (!w_do_push && w_do_pop)
            w_count_next = r_count - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_head  <= '0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + AW'(1);
            if (w_do_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CNTW'(DEPTH));
            // The head register tracks what mem[r_rd] will hold after this edge.
            if (w_do_push && (r_empty || (w_do_pop && r_count == CNTW'(1))))
                r_head <= wdata;
            else if (w_do_pop)
                r_head <= r_mem[r_rd + AW'(1)];
        end
    end

    assign rdata = r_head;
    assign empty = r_empty;
    assign full  = r_full;
    assign count = r_count;
endmodule

// File: rtl/hash_result_collector.sv
// Round-robin collector: reads each ready macro's 4-byte nonce and queues {index, nonce}.
// Define DECRED_RESULT_IRQ_EN to drive RESULT_IRQ; otherwise it is tied low.
module hash_result_collector
    import hash_result_collector_pkg::*;
#(
    parameter int         NUM_MACROS      = `NUMBER_OF_MACROS,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [5:0] NONCE_BASE_ADDR = `NONCE_BASE_ADDR,
    localparam int        IDXW            = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1,
    localparam int        CNTW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  M1_CLK,
    input  logic                  RSTn,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]            HASH_ADDR,
    input  logic [7:0]            DATA_FROM_HASH,
    input  logic                  POP,
    output logic [32+IDXW-1:0]    RESULT_DATA,
    output logic                  FIFO_EMPTY,
    output logic [CNTW-1:0]       FIFO_COUNT,
    output logic                  OVERFLOW,
    input  logic                  CLEAR_OVERFLOW,
    output logic                  RESULT_IRQ
);
    logic [1:0]            r_state;
    logic [IDXW-1:0]       r_rr_ptr;
    logic [IDXW-1:0]       r_grant;
    logic [2:0]            r_cnt;
    logic [23:0]           r_nonce_lo;
    logic [NUM_MACROS-1:0] r_sel;
    logic [5:0]            r_addr;
    logic                  r_ovf;
    logic                  w_any;
    logic [IDXW-1:0]       w_pick;
    int                    w_j;
    logic                  w_push;
    logic                  w_full;
    logic                  w_drop;
    logic [32+IDXW-1:0]    w_entry;

    // Scan downward so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_j    = 0;
        for (int i = NUM_MACROS - 1; i >= 0; i--) begin
            w_j = int'(r_rr_ptr) + i;
            if (w_j >= NUM_MACROS)
                w_j = w_j - NUM_MACROS;
            if (DATA_AVAILABLE[IDXW'(w_j)]) begin
                w_any  = 1'b1;
                w_pick = IDXW'(w_j);
            end
        end
    end

    always_ff @(posedge M1_CLK) begin
        if (!RSTn) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_sel   <= NUM_MACROS'(1) << w_pick;
                        r_addr  <= NONCE_BASE_ADDR;
                        r_cnt   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < 3'(NONCE_BYTES - 1)) begin
                        r_addr <= r_addr + 6'd1;
                    end else begin
                        r_sel  <= '0;
                        r_addr <= '0;
                    end
                    // Extra cycle after the last address collects the final byte.
                    if (r_cnt == 3'(NONCE_BYTES)) begin
                        r_cnt    <= '0;
                        r_state  <= ST_HOLDOFF;
                        r_rr_ptr <= IDXW'(wrap_inc(int'(r_grant), NUM_MACROS));
                    end
                end
                ST_HOLDOFF: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Byte k arrives while r_cnt == k+1; byte 3 goes straight into the FIFO entry.
    always_ff @(posedge M1_CLK) begin
        if (r_state == ST_READ) begin
            case (r_cnt)
                3'd1:    r_nonce_lo[7:0]   <= DATA_FROM_HASH;
                3'd2:    r_nonce_lo[15:8]  <= DATA_FROM_HASH;
                3'd3:    r_nonce_lo[23:16] <= DATA_FROM_HASH;
                default: ;
            endcase
        end
    end

    assign w_push  = (r_state == ST_READ) && (r_cnt == 3'(NONCE_BYTES));
    assign w_entry = {r_grant, DATA_FROM_HASH, r_nonce_lo};
    assign w_drop  = w_push && w_full && !POP;

    result_fifo #(
        .W     (32 + IDXW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (M1_CLK),
        .rst_n (RSTn),
        .push  (w_push),
        .pop   (POP),
        .wdata (w_entry),
        .rdata (RESULT_DATA),
        .empty (FIFO_EMPTY),
        .full  (w_full),
        .count (FIFO_COUNT)
    );

    always_ff @(posedge M1_CLK) begin
        if (!RSTn)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (CLEAR_OVERFLOW)
            r_ovf <= 1'b0;
    end

`ifdef DECRED_RESULT_IRQ_EN
    logic r_irq;
    always_ff @(posedge M1_CLK) begin
        if (!RSTn)
            r_irq <= 1'b0;
        else
            r_irq <= !FIFO_EMPTY || r_ovf;
    end
    assign RESULT_IRQ = r_irq;
`else
    assign RESULT_IRQ = 1'b0;
`endif

    assign MACRO_RD_SELECT = r_sel;
    assign HASH_ADDR       = r_addr;
    assign OVERFLOW        = r_ovf;
endmodule
